// File: rtl/latchn_bank_writer.sv
// Write-side driver for a bank of active-low-gated latches: registers one request,
// sets up shared data, pulses a single bank gate low, then holds data before idling.
module latchn_bank_writer #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_BANKS  = 4,
   parameter int SETUP_CYC  = 1,
   parameter int OPEN_CYC   = 2,
   parameter int HOLD_CYC   = 1,
   localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic                  C,
   input  logic                  R,
   input  logic                  WR_VALID,
   output logic                  WR_READY,
   input  logic [BANK_W-1:0]     WR_BANK,
   input  logic [DATA_WIDTH-1:0] WR_DATA,
   output logic [DATA_WIDTH-1:0] D,
   output logic [NUM_BANKS-1:0]  G,
   output logic                  BANK_ERR
);

   localparam int MAX_AB  = (SETUP_CYC > OPEN_CYC) ? SETUP_CYC : OPEN_CYC;
   localparam int MAX_CYC = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CNT_W-1:0]  SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0]  OPEN_LOAD  = CNT_W'(OPEN_CYC - 1);
   localparam logic [CNT_W-1:0]  HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
   localparam logic [BANK_W:0]   BANK_LIMIT = (BANK_W + 1)'(NUM_BANKS);

   if (NUM_BANKS < 1 || SETUP_CYC < 1 || OPEN_CYC < 1 || HOLD_CYC < 1) begin : g_badParams
      $error("latchn_bank_writer: NUM_BANKS and all *_CYC parameters must be >= 1");
   end

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      OPEN,
      HOLD
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic [BANK_W-1:0]       bank_q, bank_d;
   logic [NUM_BANKS-1:0]    gate_q, gate_d;
   logic                    ready_q, ready_d;
   logic                    err_q, err_d;
   logic [NUM_BANKS-1:0]    openMask;
   logic                    bankInRange;

   // Every output comes straight from a flop so the latch gates can never glitch.
   always_ff @(posedge C or negedge R) begin
      if (!R) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         bank_q  <= '0;
         gate_q  <= '1;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         bank_q  <= bank_d;
         gate_q  <= gate_d;
         ready_q <= ready_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      openMask = '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
         openMask[i] = (bank_q == BANK_W'(i));
      end
   end

   assign bankInRange = ({1'b0, WR_BANK} < BANK_LIMIT);

   // One down-counter is reused by every timed phase; each phase reloads it on exit.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      bank_d  = bank_q;
      gate_d  = gate_q;
      ready_d = ready_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            ready_d = 1'b1;
            gate_d  = '1;
            if (WR_VALID && ready_q) begin
               if (bankInRange) begin
                  data_d  = WR_DATA;
                  bank_d  = WR_BANK;
                  ready_d = 1'b0;
                  cnt_d   = SETUP_LOAD;
                  state_d = SETUP;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         SETUP: begin
            if (cnt_q == '0) begin
               gate_d  = ~openMask;
               cnt_d   = OPEN_LOAD;
               state_d = OPEN;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         OPEN: begin
            if (cnt_q == '0) begin
               gate_d  = '1;
               cnt_d   = HOLD_LOAD;
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         HOLD: begin
            if (cnt_q == '0) begin
               ready_d = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            gate_d  = '1;
         end
      endcase
   end

   assign WR_READY = ready_q;
   assign D        = data_q;
   assign G        = gate_q;
   assign BANK_ERR = err_q;

endmodule
